ioctl_upload_reader: RTL and testbench
======================================

# ioctl_upload_reader

Streams a block of core-side RAM (hiscore/NVRAM) back to the SPI host through the data_io upload path. It is the read-side counterpart of the ROM download controller: the host drives per-byte read strobes with a byte address, and this block fetches from a synchronous RAM and presents the byte on `ioctl_din`. It sits beside data_io in the `clk_sys` domain and owns the RAM read port while an upload is active.

## Interface
Parameters:
- `ADDR_W`, 10: RAM address width.
- `LEN`, 1024: payload length in bytes, ≤ 2^ADDR_W.
- `INDEX`, 8'h04: `ioctl_index` value this block answers to.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_upload`  in  1  host upload window active.
- `ioctl_index`  in  8  upload target selector.
- `ioctl_rd`  in  1  one-cycle read strobe from data_io.
- `ioctl_addr`  in  25  requested byte address, valid with `ioctl_rd`.
- `ioctl_din`  out  8  byte returned to data_io.
- `mem_addr`  out  ADDR_W  RAM read address.
- `mem_rd`  out  1  RAM read enable.
- `mem_q`  in  8  RAM data, valid one cycle after `mem_rd`.
- `busy`  out  1  fetch in progress.
- `done`  out  1  one-cycle pulse when the final byte is latched.
- `overrun`  out  1  sticky: a strobe arrived while busy.

## Operation
- `active` = `ioctl_upload` && `ioctl_index == INDEX`. Strobes while not active are ignored.
- Rising edge of `active` is the session start: clear `overrun`, checksum accumulator, sequence error, and set expected address to 0.
- FSM states:
  - IDLE: on `ioctl_rd` go to FETCH, capture `ioctl_addr`.
  - FETCH: `mem_rd`=1, `mem_addr`=captured[ADDR_W-1:0]; go to WAIT.
  - WAIT: go to LATCH.
  - LATCH: `ioctl_din` ← selected byte; go to IDLE.
- Selected byte for address < LEN is `mem_q`. Addresses ≥ LEN return 8'hFF, except the checksum bytes (see Configuration). For out-of-range addresses FETCH still occurs but `mem_rd`=0.
- `busy` = state ≠ IDLE. A `ioctl_rd` while busy is dropped and sets `overrun`. A strobe in the same cycle as LATCH→IDLE is also dropped.
- Falling edge of `active` during FETCH/WAIT/LATCH: return to IDLE next cycle; `ioctl_din` keeps its last value; no `done`.
- Sequence tracking: each captured address is compared to the expected address, which increments after each LATCH. A mismatch sets sticky `seq_err` (internal), cleared at session start.
- `done` pulses in the LATCH cycle of the last payload address (LEN-1, or LEN+1 with checksum).

## Timing
- Reset values: `ioctl_din`=8'h00, `mem_addr`=0, `mem_rd`=0, `busy`=0, `done`=0, `overrun`=0, FSM=IDLE.
- Latency: `ioctl_rd` at cycle N → `mem_rd` at N+1 → `ioctl_din` valid from N+3 and held until the next LATCH.
- Minimum strobe spacing: 4 cycles. data_io strobes at SPI byte rate, so it is always ≥ 4 cycles.
- Asynchronous reset mid-fetch: all state is cleared immediately and no pulse is emitted.

## Configuration
- `HISCORE_CHECKSUM_EN` defined:
  - A 16-bit accumulator adds each byte latched for address < LEN, wrapping modulo 2^16.
  - Address LEN returns sum[7:0]; address LEN+1 returns sum[15:8].
  - If `seq_err` is set, both checksum bytes return 8'h00.
  - `done` fires on LEN+1.
- Not defined: no accumulator is built, addresses LEN and LEN+1 return 8'hFF, and `done` fires on LEN-1.

## Test plan
- LEN=4, RAM={11,22,33,44}: strobes at addr 0..3 every 8 cycles → `ioctl_din` 11,22,33,44, each valid 3 cycles after its strobe; `done` pulses once on addr 3 (no macro).
- With the macro and the same RAM, addr 0..5 sequential → addr 4 returns 8'hAA, addr 5 returns 8'h00, `done` on addr 5.
- With the macro, order 0,2,1,3,4,5 → addr 4 and 5 return 8'h00.
- Strobe at addr 1 then a second strobe 1 cycle later → second strobe dropped, `overrun`=1; `overrun`=0 after the next session start.
- Strobe with `ioctl_index`≠INDEX → no `mem_rd`, `ioctl_din` unchanged; addr 9 with LEN=4 → 8'hFF.
- `reset_n` low during WAIT → all outputs at reset values in the same cycle; first strobe after release is served normally.

Source files
------------

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader
//   Streams a block of core-side RAM (hiscore/NVRAM) back to the SPI host
//   through the data_io upload path. data_io issues one-cycle read strobes
//   with a byte address; this block fetches the byte from a synchronous RAM
//   and holds it on ioctl_din until the next fetch completes.
//
//   Optional feature macro: HISCORE_CHECKSUM_EN
//     defined   : a 16-bit sum of the payload bytes is appended at LEN
//                 (low byte) and LEN+1 (high byte). Both bytes read 8'h00
//                 if the host read the payload out of order. done fires on
//                 LEN+1.
//     undefined : addresses >= LEN read 8'hFF and done fires on LEN-1.
//
// Ports
//   clk_sys       system clock
//   reset_n       asynchronous active-low reset
//   ioctl_upload  host upload window active
//   ioctl_index   upload target selector, block answers to INDEX
//   ioctl_rd      one-cycle read strobe
//   ioctl_addr    requested byte address, valid with ioctl_rd
//   ioctl_din     byte returned to data_io
//   mem_addr      RAM read address
//   mem_rd        RAM read enable
//   mem_q         RAM read data, valid one cycle after mem_rd
//   busy          fetch in progress
//   done          one-cycle pulse when the final payload byte is latched
//   overrun       sticky, a strobe arrived while busy

module ioctl_upload_reader #(
   parameter int          ADDR_W = 10,
   parameter int          LEN    = 1024,
   parameter logic [7:0]  INDEX  = 8'h04
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_q,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   // state   | meaning
   // --------+-----------------------------------------------
   // S_IDLE  | waiting for a read strobe
   // S_FETCH | RAM read issued for the captured address
   // S_WAIT  | RAM data arriving; selected byte loaded at exit
   // S_LATCH | new byte visible on ioctl_din, done may pulse
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_LATCH = 2'd3
   } state_t;

   localparam logic [24:0] LEN_A  = 25'(LEN);
`ifdef HISCORE_CHECKSUM_EN
   localparam logic [24:0] LEN1_A = 25'(LEN + 1);
   localparam logic [24:0] LAST_A = 25'(LEN + 1);
`else
   localparam logic [24:0] LAST_A = 25'(LEN - 1);
`endif

   state_t      state, state_nxt;
   logic        active, active_q, session_start;
   logic [24:0] addr_q;
   logic [7:0]  din_q;
   logic        overrun_q;
   logic        in_range;
   logic        capture;
   logic        load;
   logic [7:0]  sel_byte;

`ifdef HISCORE_CHECKSUM_EN
   logic [15:0] sum_q;
   logic [24:0] exp_addr;
   logic        seq_err;
`endif

   assign active        = ioctl_upload && (ioctl_index == INDEX);
   assign session_start = active && !active_q;
   assign in_range      = addr_q < LEN_A;
   assign capture       = (state == S_IDLE) && active && ioctl_rd;
   // The byte is registered while leaving WAIT so it is already visible
   // during LATCH, three cycles after the strobe.
   assign load          = (state == S_WAIT) && active;

   always_comb begin
      sel_byte = 8'hFF;
      if (in_range) begin
         sel_byte = mem_q;
      end
`ifdef HISCORE_CHECKSUM_EN
      else if (addr_q == LEN_A) begin
         sel_byte = seq_err ? 8'h00 : sum_q[7:0];
      end else if (addr_q == LEN1_A) begin
         sel_byte = seq_err ? 8'h00 : sum_q[15:8];
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (capture) state_nxt = S_FETCH;
         S_FETCH: state_nxt = active ? S_WAIT : S_IDLE;
         S_WAIT:  state_nxt = active ? S_LATCH : S_IDLE;
         S_LATCH: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         active_q  <= 1'b0;
         addr_q    <= '0;
         din_q     <= 8'h00;
         overrun_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         active_q <= active;
         if (capture) addr_q <= ioctl_addr;
         if (load)    din_q  <= sel_byte;
         if (session_start) overrun_q <= 1'b0;
         // A strobe during LATCH is also dropped since busy is still high.
         if (active && ioctl_rd && (state != S_IDLE)) overrun_q <= 1'b1;
      end
   end

`ifdef HISCORE_CHECKSUM_EN
   logic [24:0] exp_cur;
   // A strobe on the very first active cycle must compare against 0.
   assign exp_cur = session_start ? 25'd0 : exp_addr;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sum_q    <= 16'h0000;
         exp_addr <= '0;
         seq_err  <= 1'b0;
      end else begin
         if (session_start) begin
            sum_q    <= 16'h0000;
            exp_addr <= '0;
            seq_err  <= 1'b0;
         end
         if (capture && (ioctl_addr != exp_cur)) seq_err <= 1'b1;
         if (load && in_range) sum_q <= sum_q + {8'h00, mem_q};
         if ((state == S_LATCH) && active) exp_addr <= exp_addr + 25'd1;
      end
   end
`endif

   assign ioctl_din = din_q;
   assign mem_addr  = addr_q[ADDR_W-1:0];
   assign mem_rd    = (state == S_FETCH) && in_range;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_LATCH) && active && (addr_q == LAST_A);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
module tb_ioctl_upload_reader;

   localparam int ADDR_W = 10;
   localparam int LEN    = 4;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_upload = 1'b0;
   logic [7:0]  ioctl_index = 8'h04;
   logic        ioctl_rd = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_din;
   logic [ADDR_W-1:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_q = 8'h00;
   logic        busy;
   logic        done;
   logic        overrun;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;

   logic [7:0] ram [0:(1<<ADDR_W)-1];

   always #5 clk_sys = ~clk_sys;

   ioctl_upload_reader #(.ADDR_W(ADDR_W), .LEN(LEN), .INDEX(8'h04)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
      .ioctl_din(ioctl_din), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_q(mem_q), .busy(busy), .done(done), .overrun(overrun)
   );

   always @(posedge clk_sys) begin
      if (mem_rd) mem_q <= ram[mem_addr];
      if (done) done_cnt <= done_cnt + 1;
   end

   // Issue a strobe and sample: FETCH cycle (mem_rd/mem_addr), LATCH cycle
   // (din/done) and din again near the end of an 8-cycle slot.
   task automatic do_read(input logic [24:0] a,
                          output logic mrd, output logic [ADDR_W-1:0] maddr,
                          output logic [7:0] din_n3, output logic dn,
                          output logic [7:0] din_late);
      @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = a;
      @(negedge clk_sys); ioctl_rd = 1'b0; mrd = mem_rd; maddr = mem_addr;
      @(negedge clk_sys);
      @(negedge clk_sys); din_n3 = ioctl_din; dn = done;
      repeat (4) @(negedge clk_sys);
      din_late = ioctl_din;
   endtask

   task automatic new_session();
      @(negedge clk_sys); ioctl_upload = 1'b0;
      @(negedge clk_sys); ioctl_upload = 1'b1; ioctl_index = 8'h04;
      @(negedge clk_sys);
   endtask

   task automatic test_reset();
      #1;
      tests++; if (ioctl_din !== 8'h00) begin fails++; $display("FAIL reset_din got %h want 00", ioctl_din); end
      tests++; if (mem_addr !== '0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      tests++; if ({mem_rd, busy, done, overrun} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", {mem_rd, busy, done, overrun}); end
      @(negedge clk_sys); reset_n = 1'b1;
   endtask

   task automatic test_sequential();
      logic [7:0] exp_din [0:5];
      logic       exp_done [0:5];
      logic mrd, dn; logic [ADDR_W-1:0] maddr; logic [7:0] d3, dl;
      int d0;
      exp_din[0] = 8'h11; exp_din[1] = 8'h22; exp_din[2] = 8'h33; exp_din[3] = 8'h44;
`ifdef HISCORE_CHECKSUM_EN
      exp_din[4] = 8'hAA; exp_din[5] = 8'h00;
      for (int i = 0; i < 6; i++) exp_done[i] = (i == 5);
`else
      exp_din[4] = 8'hFF; exp_din[5] = 8'hFF;
      for (int i = 0; i < 6; i++) exp_done[i] = (i == 3);
`endif
      new_session();
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) begin
         do_read(25'(i), mrd, maddr, d3, dn, dl);
         tests++; if (mrd !== (i < LEN)) begin fails++; $display("FAIL seq_mem_rd addr %0d got %b want %b", i, mrd, (i < LEN)); end
         tests++; if (maddr !== ADDR_W'(i)) begin fails++; $display("FAIL seq_mem_addr addr %0d got %h want %h", i, maddr, i); end
         tests++; if (d3 !== exp_din[i]) begin fails++; $display("FAIL seq_din addr %0d got %h want %h", i, d3, exp_din[i]); end
         tests++; if (dl !== exp_din[i]) begin fails++; $display("FAIL seq_din_hold addr %0d got %h want %h", i, dl, exp_din[i]); end
         tests++; if (dn !== exp_done[i]) begin fails++; $display("FAIL seq_done addr %0d got %b want %b", i, dn, exp_done[i]); end
      end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL seq_done_count got %0d want 1", done_cnt - d0); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL seq_overrun got %b want 0", overrun); end
   endtask

   task automatic test_out_of_order();
      int order [0:5];
      logic mrd, dn; logic [ADDR_W-1:0] maddr; logic [7:0] d3, dl;
      logic [7:0] exp_ck;
`ifdef HISCORE_CHECKSUM_EN
      exp_ck = 8'h00;
`else
      exp_ck = 8'hFF;
`endif
      order[0] = 0; order[1] = 2; order[2] = 1; order[3] = 3; order[4] = 4; order[5] = 5;
      new_session();
      for (int i = 0; i < 6; i++) begin
         do_read(25'(order[i]), mrd, maddr, d3, dn, dl);
         if (order[i] >= 4) begin
            tests++; if (d3 !== exp_ck) begin fails++; $display("FAIL ooo_ck addr %0d got %h want %h", order[i], d3, exp_ck); end
         end else if (order[i] == 2) begin
            tests++; if (d3 !== 8'h33) begin fails++; $display("FAIL ooo_din addr 2 got %h want 33", d3); end
         end
      end
   endtask

   task automatic test_overrun();
      logic fetch_rd; logic [ADDR_W-1:0] fetch_addr;
      new_session();
      @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'd1;
      @(negedge clk_sys); ioctl_addr = 25'd2; fetch_rd = mem_rd; fetch_addr = mem_addr;
      @(negedge clk_sys); ioctl_rd = 1'b0;
      @(negedge clk_sys);
      tests++; if (ioctl_din !== 8'h22) begin fails++; $display("FAIL ovr_din got %h want 22", ioctl_din); end
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", overrun); end
      tests++; if (fetch_addr !== ADDR_W'(1) || fetch_rd !== 1'b1) begin fails++; $display("FAIL ovr_fetch got %h/%b want 001/1", fetch_addr, fetch_rd); end
      repeat (4) @(negedge clk_sys);
      tests++; if (ioctl_din !== 8'h22 || busy !== 1'b0) begin fails++; $display("FAIL ovr_dropped din %h busy %b want 22/0", ioctl_din, busy); end
      new_session();
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", overrun); end
   endtask

   task automatic test_inactive_and_range();
      logic saw_rd, saw_busy;
      logic mrd, dn; logic [ADDR_W-1:0] maddr; logic [7:0] d3, dl;
      saw_rd = 1'b0; saw_busy = 1'b0;
      @(negedge clk_sys); ioctl_index = 8'h05;
      @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'd0;
      @(negedge clk_sys); ioctl_rd = 1'b0;
      for (int i = 0; i < 5; i++) begin
         saw_rd |= mem_rd; saw_busy |= busy;
         @(negedge clk_sys);
      end
      tests++; if (saw_rd !== 1'b0 || saw_busy !== 1'b0) begin fails++; $display("FAIL idx_ignored mem_rd %b busy %b want 0/0", saw_rd, saw_busy); end
      tests++; if (ioctl_din !== 8'h22) begin fails++; $display("FAIL idx_din got %h want 22", ioctl_din); end
      new_session();
      do_read(25'd9, mrd, maddr, d3, dn, dl);
      tests++; if (mrd !== 1'b0) begin fails++; $display("FAIL oor_mem_rd got %b want 0", mrd); end
      tests++; if (d3 !== 8'hFF) begin fails++; $display("FAIL oor_din got %h want FF", d3); end
      tests++; if (dn !== 1'b0) begin fails++; $display("FAIL oor_done got %b want 0", dn); end
   endtask

   task automatic test_reset_mid_fetch();
      logic mrd, dn; logic [ADDR_W-1:0] maddr; logic [7:0] d3, dl;
      int d0;
      new_session();
      d0 = done_cnt;
      @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'd3;
      @(negedge clk_sys); ioctl_rd = 1'b0;
      @(posedge clk_sys); #2;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_pre_busy got %b want 1", busy); end
      reset_n = 1'b0; #1;
      tests++; if (ioctl_din !== 8'h00) begin fails++; $display("FAIL rst_mid_din got %h want 00", ioctl_din); end
      tests++; if ({mem_rd, busy, done, overrun} !== 4'b0000 || mem_addr !== '0) begin fails++; $display("FAIL rst_mid_flags got %b/%h want 0000/0", {mem_rd, busy, done, overrun}, mem_addr); end
      repeat (3) @(negedge clk_sys);
      tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL rst_mid_done got %0d want 0", done_cnt - d0); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      do_read(25'd0, mrd, maddr, d3, dn, dl);
      tests++; if (d3 !== 8'h11 || mrd !== 1'b1) begin fails++; $display("FAIL rst_after_read got %h/%b want 11/1", d3, mrd); end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h5A;
      ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
      test_reset();
      test_sequential();
      test_out_of_order();
      test_overrun();
      test_inactive_and_range();
      test_reset_mid_fetch();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
